inference_monitor: RTL and testbench

//  Memory-mapped run monitor on the SoC data bus for MLP inference runs. Replaces testbench GPR probing.

---
 rtl/inference_monitor.sv | 151 +++++++++++++++
 tb/tb_inference_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inference_monitor.sv
// Memory-mapped run monitor for MLP inference: counts images and correct predictions,
// times the run with a 64-bit cycle counter and flags exit, overflow or timeout.
module inference_monitor #(
  parameter int unsigned       DWidth        = 32,
  parameter logic [DWidth-1:0] BaseAddr      = 32'h0200_4000,
  parameter int unsigned       NumOfTest     = 10,
  parameter logic [DWidth-1:0] ExitCode      = 32'd99999,
  parameter logic [31:0]       TimeoutCycles = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic              ready_o,
  output logic [DWidth-1:0] rdata_o,
  output logic              done_o,
  output logic              error_o,
  output logic [DWidth-1:0] correct_cnt_o,
  output logic [DWidth-1:0] img_cnt_o
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2, StErr = 2'd3} state_e;

  localparam logic [5:0] OffCtrl    = 6'h00;
  localparam logic [5:0] OffLabel   = 6'h04;
  localparam logic [5:0] OffPred    = 6'h08;
  localparam logic [5:0] OffExit    = 6'h0C;
  localparam logic [5:0] OffCorrect = 6'h10;
  localparam logic [5:0] OffImgCnt  = 6'h14;
  localparam logic [5:0] OffCycLo   = 6'h18;
  localparam logic [5:0] OffCycHi   = 6'h1C;
  localparam logic [5:0] OffStatus  = 6'h20;

  state_e            state_q, state_d;
  logic              ready_q, acc_wr_q;
  logic [5:0]        acc_off_q;
  logic [DWidth-1:0] acc_wdata_q;
  logic [DWidth-1:0] label_q, pred_q, correct_q, img_q;
  logic [63:0]       cyc_q;
  logic [31:0]       cyc_hi_snap_q;

  logic hit, accept, wr_en, start, commit, overflow, exit_hit, timeout;

  assign hit    = (addr_i[DWidth-1:6] == BaseAddr[DWidth-1:6]);
  assign accept = req_i & hit & ~ready_q;

  // Writes are applied on the edge that closes the ready_o cycle.
  assign wr_en    = ready_q & acc_wr_q;
  assign start    = wr_en & (acc_off_q == OffCtrl) & acc_wdata_q[0];
  assign commit   = wr_en & (acc_off_q == OffPred) & (state_q == StRun);
  assign overflow = commit & (img_q == DWidth'(NumOfTest));
  assign exit_hit = wr_en & (acc_off_q == OffExit) & (acc_wdata_q == ExitCode) &
                    (state_q == StRun);
  assign timeout  = (state_q == StRun) & (TimeoutCycles != 32'd0) &
                    (cyc_q == 64'(TimeoutCycles));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q     <= 1'b0;
      acc_wr_q    <= 1'b0;
      acc_off_q   <= '0;
      acc_wdata_q <= '0;
    end else begin
      ready_q <= accept;
      if (accept) begin
        acc_wr_q    <= write_i;
        acc_off_q   <= addr_i[5:0];
        acc_wdata_q <= wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:        if (start) state_d = StRun;
      StRun: begin
        if (start)                    state_d = StRun;
        else if (overflow || timeout) state_d = StErr;
        else if (exit_hit)            state_d = StDone;
      end
      StDone, StErr: if (start) state_d = StRun;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    done_o  = (state_q == StDone);
    error_o = (state_q == StErr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      label_q       <= '0;
      pred_q        <= '0;
      correct_q     <= '0;
      img_q         <= '0;
      cyc_q         <= '0;
      cyc_hi_snap_q <= '0;
    end else begin
      if (start) begin
        label_q   <= '0;
        correct_q <= '0;
        img_q     <= '0;
        cyc_q     <= '0;
      end else begin
        if (wr_en && acc_off_q == OffLabel) label_q <= acc_wdata_q;
        if (wr_en && acc_off_q == OffPred)  pred_q  <= acc_wdata_q;
        // Counts only move while the run stays live; the failing commit is not counted.
        if (commit && state_d == StRun) begin
          img_q <= img_q + 1'b1;
          if (acc_wdata_q == label_q) correct_q <= correct_q + 1'b1;
        end
        if (state_q == StRun && state_d == StRun) cyc_q <= cyc_q + 64'd1;
      end
      if (ready_q && !acc_wr_q && acc_off_q == OffCycLo) cyc_hi_snap_q <= cyc_q[63:32];
    end
  end

  always_comb begin
    rdata_o = '0;
    if (ready_q && !acc_wr_q) begin
      case (acc_off_q)
        OffCtrl:    rdata_o = DWidth'(state_q);
        OffLabel:   rdata_o = label_q;
        OffPred:    rdata_o = pred_q;
        OffCorrect: rdata_o = correct_q;
        OffImgCnt:  rdata_o = img_q;
        OffCycLo:   rdata_o = DWidth'(cyc_q[31:0]);
        OffCycHi:   rdata_o = DWidth'(cyc_hi_snap_q);
        OffStatus:  rdata_o = DWidth'({error_o, done_o, state_q});
        default:    rdata_o = '0;
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign correct_cnt_o = correct_q;
  assign img_cnt_o     = img_q;

endmodule

// File: tb/tb_inference_monitor.sv
// Directed bench for inference_monitor: read expectations are queued when a read is issued
// and compared when ready_o returns; a second instance exercises a short timeout.
module tb_inference_monitor;

  localparam logic [31:0] Base      = 32'h0200_4000;
  localparam logic [5:0]  RCtrl     = 6'h00;
  localparam logic [5:0]  RLabel    = 6'h04;
  localparam logic [5:0]  RPred     = 6'h08;
  localparam logic [5:0]  RExit     = 6'h0C;
  localparam logic [5:0]  RCorrect  = 6'h10;
  localparam logic [5:0]  RImgCnt   = 6'h14;
  localparam logic [5:0]  RCycLo    = 6'h18;
  localparam logic [5:0]  RCycHi    = 6'h1C;
  localparam logic [5:0]  RStatus   = 6'h20;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst, req, req_to, write;
  logic [31:0] addr, wdata;
  logic        ready, done, error, ready_to, done_to, error_to;
  logic [31:0] rdata, correct_cnt, img_cnt, rdata_to, correct_to, img_to;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_tb = 0;
  sb_item_t    sb[$];

  inference_monitor dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .write_i(write), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready), .rdata_o(rdata), .done_o(done), .error_o(error),
    .correct_cnt_o(correct_cnt), .img_cnt_o(img_cnt)
  );

  inference_monitor #(.TimeoutCycles(32'd50)) dut_to (
    .clk_i(clk), .rst_i(rst), .req_i(req_to), .write_i(write), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready_to), .rdata_o(rdata_to), .done_o(done_to), .error_o(error_to),
    .correct_cnt_o(correct_to), .img_cnt_o(img_to)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_tb <= cyc_tb + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; ready_o must arrive exactly one cycle after req_i.
  task automatic access(input bit to, input bit wr, input logic [5:0] off,
                        input logic [31:0] data, input logic [31:0] exp, input string tag);
    sb_item_t it;
    logic     rdy;
    logic [31:0] rd;
    if (!wr) begin
      it.tag = tag;
      it.exp = exp;
      sb.push_back(it);
    end
    write = wr;
    addr  = Base + 32'(off);
    wdata = data;
    if (to) req_to = 1'b1; else req = 1'b1;
    @(posedge clk); #1;
    rdy = to ? ready_to : ready;
    rd  = to ? rdata_to : rdata;
    req = 1'b0;
    req_to = 1'b0;
    if (!rdy) check({tag, "_ready"}, {31'd0, rdy}, 32'd1);
    if (!wr) begin
      it = sb.pop_front();
      check(it.tag, rdy ? rd : 32'hDEAD_BEEF, it.exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit to, input logic [5:0] off, input logic [31:0] data);
    access(to, 1'b1, off, data, 32'd0, "write");
  endtask

  task automatic rd(input bit to, input logic [5:0] off, input logic [31:0] exp,
                    input string tag);
    access(to, 1'b0, off, 32'd0, exp, tag);
  endtask

  initial begin
    int unsigned start_edge, exit_edge, n, rdy_cnt;
    rst = 1'b1; req = 1'b0; req_to = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_done_error", {30'd0, done, error}, 32'd0);
    check("rst_counts", correct_cnt | img_cnt, 32'd0);
    rst = 1'b0;

    // Reset landing on the ready_o cycle must cancel the pending start write.
    write = 1'b1; addr = Base + 32'(RCtrl); wdata = 32'd1; req = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready_dropped", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    rd(0, RStatus, 32'h0, "status_after_reset");

    // Start and ten commits, 3 and 7 wrong.
    wr(0, RCtrl, 32'd1);
    rd(0, RStatus, 32'h1, "status_run");
    rd(0, RCtrl, 32'h1, "ctrl_state_run");
    for (int i = 0; i < 10; i++) begin
      wr(0, RLabel, 32'(i));
      wr(0, RPred, (i == 3 || i == 7) ? 32'(i + 100) : 32'(i));
    end
    rd(0, RCorrect, 32'd8, "correct_8");
    rd(0, RImgCnt, 32'd10, "imgcnt_10");
    rd(0, RLabel, 32'd9, "label_last");
    rd(0, RPred, 32'd9, "pred_last");
    check("port_correct", correct_cnt, 32'd8);
    check("port_imgcnt", img_cnt, 32'd10);
    check("no_error_10", {31'd0, error}, 32'd0);

    // Eleventh commit overflows; EXIT afterwards must not leave ERR.
    wr(0, RPred, 32'd9);
    check("overflow_error", {31'd0, error}, 32'd1);
    rd(0, RImgCnt, 32'd10, "imgcnt_frozen");
    rd(0, RCorrect, 32'd8, "correct_frozen");
    wr(0, RExit, 32'd99999);
    rd(0, RStatus, 32'hB, "status_err_after_exit");
    check("no_done_in_err", {31'd0, done}, 32'd0);

    // New run: wrong exit code ignored, right one ends the run and freezes the timer.
    wr(0, RCtrl, 32'd1);
    start_edge = cyc_tb;
    check("restart_clears_error", {31'd0, error}, 32'd0);
    rd(0, RImgCnt, 32'd0, "imgcnt_cleared");
    rd(0, RLabel, 32'd0, "label_cleared");
    wr(0, RExit, 32'd12345);
    rd(0, RStatus, 32'h1, "status_after_bad_exit");
    wr(0, RExit, 32'd99999);
    exit_edge = cyc_tb;
    // Counter is 0 on the edge that starts the run and +1 on each later RUN edge.
    n = exit_edge - start_edge - 1;
    check("done_set", {31'd0, done}, 32'd1);
    rd(0, RStatus, 32'h6, "status_done");
    rd(0, RCycLo, n, "cyclo_at_exit");
    repeat (5) @(posedge clk);
    #1;
    rd(0, RCycLo, n, "cyclo_frozen");
    rd(0, RCycHi, 32'd0, "cychi_snap");
    wr(0, RPred, 32'd0);
    rd(0, RImgCnt, 32'd0, "pred_ignored_in_done");

    // Address outside the window gets no response.
    write = 1'b0; addr = 32'h0200_4100; req = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready) rdy_cnt++;
    end
    req = 1'b0;
    check("miss_no_ready", rdy_cnt, 32'd0);

    // req held through the ready_o cycle yields exactly one commit.
    wr(0, RCtrl, 32'd1);
    wr(0, RLabel, 32'd5);
    write = 1'b1; addr = Base + 32'(RPred); wdata = 32'd5; req = 1'b1;
    rdy_cnt = 0;
    @(posedge clk); #1;
    if (ready) rdy_cnt++;
    @(posedge clk); #1;
    if (ready) rdy_cnt++;
    req = 1'b0;
    @(posedge clk); #1;
    if (ready) rdy_cnt++;
    check("held_req_one_ready", rdy_cnt, 32'd1);
    rd(0, RImgCnt, 32'd1, "held_req_imgcnt");
    rd(0, RCorrect, 32'd1, "held_req_correct");

    // Timeout instance: error once the counter reaches 50.
    wr(1, RCtrl, 32'd1);
    repeat (44) @(posedge clk);
    #1;
    check("to_not_yet", {31'd0, error_to}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("to_error", {31'd0, error_to}, 32'd1);
    rd(1, RStatus, 32'hB, "to_status_err");
    rd(1, RCycLo, 32'd50, "to_cyclo_50");
    wr(1, RCtrl, 32'd1);
    check("to_error_cleared", {31'd0, error_to}, 32'd0);
    // The earliest possible read completes one RUN cycle after the clear.
    rd(1, RCycLo, 32'd1, "to_cyclo_cleared");
    rd(1, RCycHi, 32'd0, "to_cychi_cleared");
    rd(1, RStatus, 32'h1, "to_status_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
